uart_collector: RTL and testbench

UART receiver that turns an 8N1 serial line back into the byte stream the core-side logic consumes. It is the receive-side counterpart of the emitter: the emitter serialises an AXI-stream byte stream onto `o_uart_tx`, and this block samples a serial input and presents the bytes as an AXI-stream with `tlast` framing and a small elastic buffer. It sits between a board pin and any stream consumer, in the same clock domain as the core.

---
 rtl/uart_collector.sv | 165 ++++++++++++++++
 tb/tb_uart_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_collector.sv
// uart_collector: 8N1 UART receiver that presents received bytes as an AXI-stream.
//
// The serial input is synchronised, then decoded by a start/data/stop FSM. Each
// good byte goes into a small FIFO, tagged with tlast when it equals LAST_CHAR.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_uart_rx    asynchronous serial input, idle high
//   o_tdata      byte at the FIFO head (0 when empty)
//   o_tlast      head byte equals LAST_CHAR (0 when empty)
//   o_tvalid     FIFO not empty
//   i_tready     consumer accepts the head entry
//   o_frame_err  one-cycle pulse when a stop bit samples low
//   o_overrun    sticky: a good byte was dropped because the FIFO was full
module uart_collector #(
    parameter int unsigned CLKS_PER_BIT = 278,
    parameter int unsigned DEPTH        = 4,
    parameter logic [7:0]  LAST_CHAR    = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW   = $clog2(DEPTH);

    localparam logic [CntW-1:0] HalfTc = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitTc  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [AW:0]     PtrOne = (AW + 1)'(1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    // Input synchroniser; resets to the idle (high) line level.
    logic rx_meta_q, rx_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_s      <= rx_meta_q;
        end
    end

    // Receive FSM
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            push;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntOne;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                // Mid-start-bit check; a line already back high was only a glitch.
                if (cnt_q == HalfTc) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitTc) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == BitTc) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold off until the line returns high so a break is not read as 0x00s.
                cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output FIFO; the extra pointer bit distinguishes full from empty.
    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, pop, push_ok, overrun_q;
    logic [8:0]  head;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = o_tvalid && i_tready;
    // A full FIFO still takes the byte if the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok)         wr_ptr_q  <= wr_ptr_q + PtrOne;
            if (pop)             rd_ptr_q  <= rd_ptr_q + PtrOne;
            if (push && !push_ok) overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {(shift_q == LAST_CHAR), shift_q};
    end

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign o_tvalid    = !empty;
    // Mask the head when empty so the outputs read 0 rather than stale data.
    assign o_tdata     = o_tvalid ? head[7:0] : 8'h00;
    assign o_tlast     = o_tvalid ? head[8] : 1'b0;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_collector.sv
// tb_uart_collector: directed bench for uart_collector with a queue-based scoreboard.
// Stimulus pushes the expected {last, data} of each byte; a negedge monitor pops and
// compares on every accepted beat, and also tracks frame errors and AXI hold rules.
module tb_uart_collector;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       tready = 1'b0;
    logic [7:0] o_tdata;
    logic       o_tlast, o_tvalid, o_frame_err, o_overrun;

    uart_collector #(
        .CLKS_PER_BIT(C),
        .DEPTH       (4),
        .LAST_CHAR   (8'h0A)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_uart_rx  (rx),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .i_tready   (tready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_e;
    logic [8:0]  prev_beat = '0;
    logic        prev_stall = 1'b0;
    int          fe_cnt = 0;
    int          hold_viol = 0;
    int          quiet_viol = 0;
    bit          quiet = 1'b0;
    int          first_valid = -1;
    int unsigned f0, fdummy;
    int          fe0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Monitor
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (o_frame_err) fe_cnt++;
            if (quiet && (o_tvalid || o_frame_err || o_overrun)) quiet_viol++;
            if (prev_stall && (!o_tvalid || {o_tlast, o_tdata} != prev_beat)) hold_viol++;
            prev_stall = o_tvalid && !tready;
            prev_beat  = {o_tlast, o_tdata};
            if (o_tvalid && first_valid < 0) first_valid = int'(cyc);
            if (o_tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected beat: got data 0x%0h last %0b, required none",
                             o_tdata, o_tlast);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("beat data", o_tdata, exp_e[7:0]);
                    check("beat last", o_tlast, exp_e[8]);
                end
            end
        end
    end

    // Each level is held C cycles; returns one cycle before the stop bit ends so
    // consecutive calls are exactly back-to-back.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int unsigned fall);
        @(posedge clk);
        #1 rx = 1'b0;
        fall = cyc;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (C) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (C - 1) @(posedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_tvalid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain within bound", (n < 3000), 1);
    endtask

    initial begin
        // Reset values
        #1;
        check("reset tvalid", o_tvalid, 0);
        check("reset tdata", o_tdata, 0);
        check("reset tlast", o_tlast, 0);
        check("reset frame_err", o_frame_err, 0);
        check("reset overrun", o_overrun, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle line
        quiet = 1'b1;
        repeat (1000) @(posedge clk);
        #1 quiet = 1'b0;
        check("idle line quiet", quiet_viol, 0);

        // Back-to-back frames and first-beat latency
        tready = 1'b1;
        first_valid = -1;
        exp_q.push_back(9'h055);
        exp_q.push_back(9'h0A3);
        exp_q.push_back(9'h10A);
        send_byte(8'h55, 1'b1, f0);
        send_byte(8'hA3, 1'b1, fdummy);
        send_byte(8'h0A, 1'b1, fdummy);
        wait_drain();
        check("first tvalid latency", first_valid - int'(f0), 155);

        // Short glitch
        fe0 = fe_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch frame_err", fe_cnt - fe0, 0);
        check("glitch tvalid", o_tvalid, 0);

        // Framing error followed by a held-low line
        fe0 = fe_cnt;
        send_byte(8'h41, 1'b0, fdummy);
        repeat (50) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        exp_q.push_back(9'h042);
        send_byte(8'h42, 1'b1, fdummy);
        wait_drain();
        check("break frame_err pulses", fe_cnt - fe0, 1);

        // Overrun with consumer stalled
        tready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) exp_q.push_back({1'b0, 8'(i)});
            send_byte(8'(i), 1'b1, fdummy);
            #1;
            if (i == 4) check("overrun after 4th", o_overrun, 0);
            if (i == 5) check("overrun after 5th", o_overrun, 1);
        end
        repeat (20) @(posedge clk);
        #1;
        check("stalled head", o_tdata, 8'h01);
        tready = 1'b1;
        wait_drain();
        check("overrun sticky", o_overrun, 1);
        rst_n = 1'b0;
        #1;
        check("overrun cleared by reset", o_overrun, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Simultaneous push and pop on a full FIFO
        tready = 1'b0;
        for (int i = 1; i <= 5; i++) exp_q.push_back({1'b0, 8'(i)});
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, fdummy);
        fork
            send_byte(8'h05, 1'b1, fdummy);
            begin
                repeat (155) @(posedge clk);
                #1 tready = 1'b1;
            end
        join
        #1;
        check("no overrun on same-cycle pop", o_overrun, 0);
        wait_drain();

        // Reset in the middle of a data phase
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (C) @(posedge clk);
        #1 rx = 1'b1;
        repeat (C) @(posedge clk);
        #1 rx = 1'b0;
        repeat (C) @(posedge clk);
        #1 begin
            rst_n = 1'b0;
            rx    = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("tvalid after mid-frame reset", o_tvalid, 0);
        exp_q.push_back(9'h07E);
        send_byte(8'h7E, 1'b1, fdummy);
        wait_drain();

        check("axi hold violations", hold_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
